// File: rtl/joypad_pkg.sv
// Shared constants and helpers for the NES standard-controller ports at $4016/$4017.
package joypad_pkg;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    localparam logic [15:0] JOY1_ADDR = 16'h4016;
    localparam logic [15:0] JOY2_ADDR = 16'h4017;

    // Idle shift value: all ones, so an unstrobed or exhausted port reads back 1.
    localparam logic [7:0] SHIFT_RESET = 8'hFF;

    // Bit 0 of the open-bus constant is forced low so the serial bit always owns D0.
    function automatic logic [7:0] read_byte(input logic [7:0] open_hi, input logic serial_bit);
        return (open_hi & 8'hFE) | {7'b0, serial_bit};
    endfunction

endpackage

// File: rtl/joypad_if.sv
// CPU-side bus bundle between the data-bus mux / address decode and the joypad ports.
interface joypad_if;

    logic       CPU_CE;
    logic       CPU_WR;
    logic [7:0] CPU_DO;
    logic       CONTROL1_EN;
    logic       CONTROL2_EN;
    logic [7:0] CONTROL1;
    logic [7:0] CONTROL2;

    modport master (
        output CPU_CE,
        output CPU_WR,
        output CPU_DO,
        output CONTROL1_EN,
        output CONTROL2_EN,
        input  CONTROL1,
        input  CONTROL2
    );

    modport slave (
        input  CPU_CE,
        input  CPU_WR,
        input  CPU_DO,
        input  CONTROL1_EN,
        input  CONTROL2_EN,
        output CONTROL1,
        output CONTROL2
    );

endinterface

// File: rtl/joypad_shift.sv
// One controller port: button synchroniser, 8-bit 1-filling shift register, read-byte OR.
module joypad_shift
    import joypad_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS_HI = 8'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       strobe,
    input  logic       read_evt,
    input  logic [7:0] buttons,
    output logic [7:0] q
);

    logic [7:0] sync_p [SYNC_STAGES];
    logic [7:0] btn_sync;
    logic [7:0] shift;

    // Stage boundary: asynchronous buttons into the synchroniser chain.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_p[i] <= '0;
            end
        end else begin
            sync_p[0] <= buttons;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_p[i] <= sync_p[i-1];
            end
        end
    end

    assign btn_sync = sync_p[SYNC_STAGES-1];

    // Stage boundary: synchronised buttons into the shift register.
    // Strobe outranks reads, so a read while strobed returns live A without shifting.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            shift <= SHIFT_RESET;
        end else if (strobe) begin
            shift <= btn_sync;
        end else if (read_evt) begin
            shift <= {1'b1, shift[7:1]};
        end
    end

    assign q = read_byte(OPEN_BUS_HI, shift[0]);

endmodule

// File: rtl/joypad_ports.sv
// NES $4016/$4017 controller ports: strobe latch, bus event decode, two serial shifters.
module joypad_ports
    import joypad_pkg::*;
#(
    parameter logic [7:0] OPEN_BUS_HI = 8'h40,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    joypad_if.slave     bus,
    input  logic [7:0]  BUTTONS1,
    input  logic [7:0]  BUTTONS2
);

    logic strobe;
    logic write_evt;
    logic read_evt1;
    logic read_evt2;
    logic unused_do_hi;

    // Only the CPU_CE clock of a bus cycle acts; $4017 writes belong to the APU.
    assign write_evt = bus.CPU_CE & ~bus.CPU_WR & bus.CONTROL1_EN;
    assign read_evt1 = bus.CPU_CE &  bus.CPU_WR & bus.CONTROL1_EN;
    assign read_evt2 = bus.CPU_CE &  bus.CPU_WR & bus.CONTROL2_EN;

    assign unused_do_hi = ^bus.CPU_DO[7:1];

    // The old strobe value governs the clearing write's own clock, so it still reloads once.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            strobe <= 1'b0;
        end else if (write_evt) begin
            strobe <= bus.CPU_DO[0];
        end
    end

    joypad_shift #(
        .OPEN_BUS_HI (OPEN_BUS_HI),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_port1 (
        .Clk      (Clk),
        .Reset    (Reset),
        .strobe   (strobe),
        .read_evt (read_evt1),
        .buttons  (BUTTONS1),
        .q        (bus.CONTROL1)
    );

    joypad_shift #(
        .OPEN_BUS_HI (OPEN_BUS_HI),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_port2 (
        .Clk      (Clk),
        .Reset    (Reset),
        .strobe   (strobe),
        .read_evt (read_evt2),
        .buttons  (BUTTONS2),
        .q        (bus.CONTROL2)
    );

endmodule

// File: tb/tb_joypad_ports.sv
// Directed self-checking bench for joypad_ports.
module tb_joypad_ports;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] buttons1 = 8'h00;
    logic [7:0] buttons2 = 8'h00;
    int         n_checks = 0;
    int         n_fail   = 0;

    joypad_if bus ();

    joypad_ports #(
        .OPEN_BUS_HI (8'h40),
        .SYNC_STAGES (2)
    ) dut (
        .Clk      (clk),
        .Reset    (rst),
        .bus      (bus),
        .BUTTONS1 (buttons1),
        .BUTTONS2 (buttons2)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_idle();
        bus.CPU_CE      = 1'b0;
        bus.CPU_WR      = 1'b1;
        bus.CPU_DO      = 8'h00;
        bus.CONTROL1_EN = 1'b0;
        bus.CONTROL2_EN = 1'b0;
    endtask

    task automatic idle(input int n);
        bus_idle();
        repeat (n) @(negedge clk);
    endtask

    task automatic do_write(input int port, input logic [7:0] data);
        bus.CPU_CE      = 1'b1;
        bus.CPU_WR      = 1'b0;
        bus.CPU_DO      = data;
        bus.CONTROL1_EN = (port == 1);
        bus.CONTROL2_EN = (port == 2);
        @(negedge clk);
        bus_idle();
    endtask

    task automatic do_read(input int port, output logic [7:0] v);
        bus.CPU_CE      = 1'b1;
        bus.CPU_WR      = 1'b1;
        bus.CONTROL1_EN = (port == 1);
        bus.CONTROL2_EN = (port == 2);
        #1;
        v = (port == 1) ? bus.CONTROL1 : bus.CONTROL2;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic strobe_cycle();
        do_write(1, 8'h01);
        do_write(1, 8'h00);
    endtask

    task automatic test_reset();
        logic [7:0] v;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.CONTROL1 !== 8'h41) begin
            n_fail++;
            $display("FAIL reset_control1 got=%h exp=%h", bus.CONTROL1, 8'h41);
        end
        n_checks++;
        if (bus.CONTROL2 !== 8'h41) begin
            n_fail++;
            $display("FAIL reset_control2 got=%h exp=%h", bus.CONTROL2, 8'h41);
        end
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            do_read(1, v);
            n_checks++;
            if (v !== 8'h41) begin
                n_fail++;
                $display("FAIL unstrobed_read%0d got=%h exp=%h", i, v, 8'h41);
            end
        end
        n_checks++;
        if (bus.CONTROL2 !== 8'h41) begin
            n_fail++;
            $display("FAIL unstrobed_control2 got=%h exp=%h", bus.CONTROL2, 8'h41);
        end
    endtask

    task automatic test_latch_sequence();
        logic [7:0] v;
        logic [7:0] exp_seq [10];
        exp_seq = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h41, 8'h41, 8'h41};
        buttons1 = 8'b1000_1001;
        idle(4);
        strobe_cycle();
        for (int i = 0; i < 10; i++) begin
            do_read(1, v);
            n_checks++;
            if (v !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL latch_read%0d got=%h exp=%h", i, v, exp_seq[i]);
            end
        end
    endtask

    task automatic test_strobe_high();
        logic       a_hist [64];
        logic       a;
        logic [7:0] v;
        buttons1 = 8'h00;
        idle(4);
        do_write(1, 8'h01);
        for (int t = 0; t < 48; t++) begin
            a         = ((t / 8) % 2) == 1;
            a_hist[t] = a;
            buttons1  = {7'b1010101, a};
            bus.CPU_CE      = (t % 3 == 0);
            bus.CPU_WR      = 1'b1;
            bus.CONTROL1_EN = (t % 3 == 0);
            #1;
            v = bus.CONTROL1;
            if (t % 3 == 0 && t >= 3) begin
                n_checks++;
                if (v !== {7'b0100000, a_hist[t-3]}) begin
                    n_fail++;
                    $display("FAIL strobe_live_a t=%0d got=%h exp=%h", t, v, {7'b0100000, a_hist[t-3]});
                end
            end
            @(negedge clk);
        end
        bus_idle();
        do_write(1, 8'h00);
    endtask

    task automatic test_ports_independent();
        logic [7:0] v;
        logic [7:0] exp1 [4];
        exp1 = '{8'h41, 8'h40, 8'h40, 8'h41};
        buttons1 = 8'b1000_1001;
        buttons2 = 8'h10;
        idle(4);
        strobe_cycle();
        for (int i = 0; i < 4; i++) begin
            do_read(2, v);
            n_checks++;
            if (v !== 8'h40) begin
                n_fail++;
                $display("FAIL port2_read%0d got=%h exp=%h", i, v, 8'h40);
            end
            do_read(1, v);
            n_checks++;
            if (v !== exp1[i]) begin
                n_fail++;
                $display("FAIL port1_interleaved%0d got=%h exp=%h", i, v, exp1[i]);
            end
        end
        do_read(2, v);
        n_checks++;
        if (v !== 8'h41) begin
            n_fail++;
            $display("FAIL port2_up_bit got=%h exp=%h", v, 8'h41);
        end
    endtask

    task automatic test_multicycle();
        logic [7:0] v;
        buttons1 = 8'hFD;
        idle(4);
        strobe_cycle();
        bus.CPU_WR      = 1'b1;
        bus.CONTROL1_EN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            bus.CPU_CE = (c == 2);
            #1;
            if (c == 0) begin
                n_checks++;
                if (bus.CONTROL1 !== 8'h41) begin
                    n_fail++;
                    $display("FAIL multicycle_first_bit got=%h exp=%h", bus.CONTROL1, 8'h41);
                end
            end
            @(negedge clk);
        end
        bus_idle();
        do_read(1, v);
        n_checks++;
        if (v !== 8'h40) begin
            n_fail++;
            $display("FAIL multicycle_single_shift got=%h exp=%h", v, 8'h40);
        end
        do_write(2, 8'h01);
        buttons1 = 8'h00;
        idle(4);
        do_read(1, v);
        n_checks++;
        if (v !== 8'h41) begin
            n_fail++;
            $display("FAIL write4017_no_strobe got=%h exp=%h", v, 8'h41);
        end
    endtask

    task automatic test_reset_mid_sequence();
        logic [7:0] v;
        logic [7:0] exp_seq [8];
        exp_seq = '{8'h41, 8'h40, 8'h40, 8'h41, 8'h40, 8'h40, 8'h40, 8'h41};
        buttons1 = 8'h00;
        idle(4);
        strobe_cycle();
        for (int i = 0; i < 3; i++) begin
            do_read(1, v);
            n_checks++;
            if (v !== 8'h40) begin
                n_fail++;
                $display("FAIL pre_reset_read%0d got=%h exp=%h", i, v, 8'h40);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        do_read(1, v);
        n_checks++;
        if (v !== 8'h41) begin
            n_fail++;
            $display("FAIL post_reset_read got=%h exp=%h", v, 8'h41);
        end
        buttons1 = 8'b1000_1001;
        idle(4);
        strobe_cycle();
        for (int i = 0; i < 8; i++) begin
            do_read(1, v);
            n_checks++;
            if (v !== exp_seq[i]) begin
                n_fail++;
                $display("FAIL fresh_seq_read%0d got=%h exp=%h", i, v, exp_seq[i]);
            end
        end
    endtask

    initial begin
        bus_idle();
        @(negedge clk);
        test_reset();
        test_latch_sequence();
        test_strobe_high();
        test_ports_independent();
        test_multicycle();
        test_reset_mid_sequence();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/joypad_ports.md
Name: joypad_ports

Overview:
- Implements the two NES standard-controller serial ports at $4016/$4017.
- Latches 8-bit button vectors on the CPU strobe write to $4016.
- Serialises one button per CPU read onto CONTROL1/CONTROL2, which feed the CPU data-bus mux.
- Sits directly upstream of the bus mux: consumes its CONTROL1_EN/CONTROL2_EN selects, CPU_WR and CPU_DO; produces the bytes the mux returns on controller reads.

Parameters:
- OPEN_BUS_HI, 8'h40: constant upper bits ORed into every controller read byte. Bit 0 must be 0.
- SYNC_STAGES, 2: flop stages synchronising the button inputs (minimum 1).

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- CPU_CE  input  1  one-cycle pulse marking the clock on which the current CPU bus cycle completes
- CPU_WR  input  1  1 = CPU read, 0 = CPU write (bus convention)
- CPU_DO  input  8  CPU write data
- CONTROL1_EN  input  1  address decode hit for $4016
- CONTROL2_EN  input  1  address decode hit for $4017
- BUTTONS1  input  8  player-1 buttons, active-high, asynchronous: bit0 A, 1 B, 2 Select, 3 Start, 4 Up, 5 Down, 6 Left, 7 Right
- BUTTONS2  input  8  player-2 buttons, same encoding
- CONTROL1  output  8  read byte for $4016
- CONTROL2  output  8  read byte for $4017

Behaviour:
- Reset (synchronous):
  - strobe <= 0
  - shift1, shift2 <= 8'hFF
  - all sync flops <= 0
  - Resulting outputs: CONTROL1 = CONTROL2 = OPEN_BUS_HI | 1 = 8'h41.
  - Reset mid-sequence aborts it; the next read after reset returns bit 1.
- Sync: BUTTONSn passes through SYNC_STAGES flops to give btn_sync_n. No debounce.
- Write event:
  - Condition: CPU_CE & ~CPU_WR & CONTROL1_EN.
  - Action: strobe <= CPU_DO[0]. CPU_DO[7:1] are ignored.
  - Writes with CONTROL2_EN are ignored ($4017 writes belong to the APU).
- Read event n:
  - Condition: CPU_CE & CPU_WR & CONTROLn_EN.
  - Ports are independent; reading port 1 never shifts port 2.
- Per-clock shift-register update, in priority order:
  1. Reset.
  2. strobe == 1: shiftn <= btn_sync_n every clock. Reads do not shift.
  3. Read event n with strobe == 0: shiftn <= {1'b1, shiftn[7:1]}.
  4. Otherwise: hold.
- Strobe release:
  - The value captured is the one loaded on the last clock with strobe = 1.
  - The write that clears strobe still reloads on that same clock, because the old strobe = 1 governs it.
- Output:
  - CONTROLn = OPEN_BUS_HI | {7'b0, shiftn[0]}, combinational from registers.
  - The bit returned by a read is the one present before that read's shift. The shift takes effect on the clock edge ending the read.
  - No read-side latency beyond the bus mux.
- Exhaustion: after 8 reads without a re-strobe, every further read returns 1 (8'h41). The 1-fill guarantees this with no counter.
- Strobe held high: every read returns the live A button, with no shift.
- Button latency: a change on BUTTONSn is visible in shiftn after SYNC_STAGES + 1 clocks while strobe = 1.
- Multi-clock bus cycles: only the CPU_CE clock acts. EN/WR held across several clocks without CPU_CE cause no extra shifts.

Decomposition:
- Shared package joypad_pkg:
  - Button bit-index constants: BTN_A = 0 … BTN_RIGHT = 7.
  - Port address constants: JOY1_ADDR = 16'h4016, JOY2_ADDR = 16'h4017.
  - Reset value constant SHIFT_RESET = 8'hFF.
- Sub-module joypad_shift, instantiated twice:
  - Contents: the synchroniser, the 8-bit shift register, and the output OR.
  - Inputs: Clk, Reset, strobe, read_evt, buttons.
  - Output: q[7:0].
- The top holds the strobe flop and the event decode.

Test Plan:
- After Reset, no strobe: 10 reads of $4016 -> every CONTROL1 = 8'h41. CONTROL2 = 8'h41.
- BUTTONS1 = 8'b1000_1001 (A, Start, Right) held 4 clocks; write $01 then $00 to $4016; 8 reads -> CONTROL1 sequence 41,40,40,41,40,40,40,41; 9th and 10th reads -> 41.
- Strobe $01 left high, BUTTONS1[0] toggled each 8 clocks, reads every 3 clocks -> CONTROL1[0] follows A with 3-clock delay (SYNC_STAGES = 2, +1). Returned bits past the first are never shifted in.
- BUTTONS2 = 8'h10 (Up); strobe cycle; 4 reads of $4017 interleaved with 4 reads of $4016 -> $4017 returns 40,40,40,40, then the 5th $4017 read returns 41. Port 1 is unaffected by port-2 reads.
- Read with CONTROL1_EN and CPU_WR held 5 clocks, CPU_CE pulsed once -> exactly one shift, observed by the next read's bit. Write to $4017 with CPU_DO = $01 -> strobe unchanged.
- Reset asserted after 3 of 8 reads -> next read returns 8'h41. A fresh strobe cycle then yields the full sequence from bit 0.
